// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences each
// instruction over 2-5 cycles and drives every datapath select and enable.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       z,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] AluControl,
  output logic [2:0] immSrc,
  output logic       Regwrite,
  output logic       done,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXECR    = 4'd6,
    ST_EXECI    = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_JAL      = 4'd9,
    ST_JALR     = 4'd10,
    ST_JALRWB   = 4'd11,
    ST_BRANCH   = 4'd12,
    ST_LUI      = 4'd13
  } state_t;

  state_t state_q;
  state_t state_d;

  logic       branch_taken_s;
  logic [2:0] branch_alu_s;
  logic       unused_func7_s;

  assign unused_func7_s = ^{func7[6], func7[4:0]};

  // ALU operation for register and immediate arithmetic; sub only exists in R-type.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                            input logic       f7_b5,
                                            input logic       is_rtype);
    logic [2:0] op;
    case (f3)
      3'b000:  op = (is_rtype && f7_b5) ? ALU_SUB : ALU_ADD;
      3'b111:  op = ALU_AND;
      3'b110:  op = ALU_OR;
      3'b100:  op = ALU_XOR;
      3'b010:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    logic [2:0] sel;
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: sel = 3'b000;
      OP_STORE:                   sel = 3'b001;
      OP_BRANCH:                  sel = 3'b010;
      OP_JAL:                     sel = 3'b011;
      OP_LUI:                     sel = 3'b100;
      default:                    sel = 3'b000;
    endcase
    return sel;
  endfunction

  // Branch comparison: eq/ne via subtract, lt/ge via slt, z judged this cycle.
  always_comb begin
    branch_taken_s = 1'b0;
    branch_alu_s   = ALU_ADD;
    case (func3)
      3'b000: begin branch_alu_s = ALU_SUB; branch_taken_s = z;  end
      3'b001: begin branch_alu_s = ALU_SUB; branch_taken_s = ~z; end
      3'b100: begin branch_alu_s = ALU_SLT; branch_taken_s = ~z; end
      3'b101: begin branch_alu_s = ALU_SLT; branch_taken_s = z;  end
      default: begin branch_alu_s = ALU_ADD; branch_taken_s = 1'b0; end
    endcase
  end

  // Next-state selection.
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = ST_MEMADR;
          OP_RTYPE:          state_d = ST_EXECR;
          OP_ITYPE:          state_d = ST_EXECI;
          OP_JAL:            state_d = ST_JAL;
          OP_JALR:           state_d = ST_JALR;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_LUI:            state_d = ST_LUI;
          default:           state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR:  state_d = (opcode == OP_LOAD) ? ST_MEMREAD : ST_MEMWRITE;
      ST_MEMREAD: state_d = ST_MEMWB;
      ST_EXECR:   state_d = ST_ALUWB;
      ST_EXECI:   state_d = ST_ALUWB;
      ST_JAL:     state_d = ST_ALUWB;
      ST_JALR:    state_d = ST_JALRWB;
      ST_MEMWB, ST_MEMWRITE, ST_ALUWB, ST_JALRWB, ST_BRANCH, ST_LUI:
                  state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  // State register with synchronous reset into FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode; everything is forced low while rst is high.
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    AluControl = ALU_ADD;
    immSrc     = 3'b000;
    Regwrite   = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    if (rst) begin
      immSrc = 3'b000;
    end else begin
      immSrc = imm_decode(opcode);
      case (state_q)
        ST_FETCH: begin
          IRWrite   = 1'b1;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        ST_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_JAL, OP_JALR, OP_BRANCH, OP_LUI: begin
              illegal = 1'b0;
              done    = 1'b0;
            end
            default: begin
              illegal = 1'b1;
              done    = 1'b1;
            end
          endcase
        end
        ST_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        ST_MEMREAD: AdrSrc = 1'b1;
        ST_MEMWB: begin
          ResultSrc = 2'b01;
          Regwrite  = 1'b1;
          done      = 1'b1;
        end
        ST_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          done     = 1'b1;
        end
        ST_EXECR: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b00;
          AluControl = alu_decode(func3, func7[5], 1'b1);
        end
        ST_EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          AluControl = alu_decode(func3, func7[5], 1'b0);
        end
        ST_ALUWB: begin
          ResultSrc = 2'b00;
          Regwrite  = 1'b1;
          done      = 1'b1;
        end
        // Link value OldPC+4 is parked in ALUOut while PC takes the target.
        ST_JAL: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b00;
          PCWrite   = 1'b1;
        end
        ST_JALR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          ResultSrc = 2'b10;
          PCWrite   = 1'b1;
        end
        ST_JALRWB: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
          Regwrite  = 1'b1;
          done      = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b00;
          ResultSrc  = 2'b00;
          AluControl = branch_alu_s;
          PCWrite    = branch_taken_s;
          done       = 1'b1;
        end
        ST_LUI: begin
          ResultSrc = 2'b11;
          Regwrite  = 1'b1;
          done      = 1'b1;
        end
        default: begin
          PCWrite = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized bench for multicycle_controller against a
// per-instruction cycle-table reference model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       z;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, Regwrite, done, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] AluControl, immSrc;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7), .z(z),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .AluControl(AluControl), .immSrc(immSrc), .Regwrite(Regwrite),
    .done(done), .illegal(illegal)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,AluControl,immSrc,Regwrite,done,illegal}
  logic [18:0] obs;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                AluControl, immSrc, Regwrite, done, illegal};

  function automatic int instr_len(input logic [6:0] op);
    case (op)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111: return 4;
      7'b1100011, 7'b0110111: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected control word for cycle `step` (0 = FETCH) of instruction `op`.
  function automatic logic [18:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input int step, input logic zz);
    logic pcw, adr, mw, irw, rw, dn, ill;
    logic [1:0] res, sa, sb;
    logic [2:0] alu, imm;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; dn = 0; ill = 0;
    res = 2'd0; sa = 2'd0; sb = 2'd0; alu = 3'd0;
    case (op)
      7'b0100011: imm = 3'd1;
      7'b1100011: imm = 3'd2;
      7'b1101111: imm = 3'd3;
      7'b0110111: imm = 3'd4;
      default:    imm = 3'd0;
    endcase
    if (step == 0) begin
      irw = 1; pcw = 1; res = 2'd2; sb = 2'd2;
    end else if (step == 1) begin
      sa = 2'd1; sb = 2'd1;
      if (instr_len(op) == 2) begin dn = 1; ill = 1; end
    end else if (step == instr_len(op) - 1 &&
                 (op == 7'b0110011 || op == 7'b0010011 || op == 7'b1101111)) begin
      rw = 1; dn = 1; res = 2'd0;   // shared write-back of ALUOut
    end else begin
      case (op)
        7'b0000011, 7'b0100011: begin
          if (step == 2) begin sa = 2'd2; sb = 2'd1; end
          else if (op == 7'b0100011) begin adr = 1; mw = 1; dn = 1; end
          else if (step == 3) adr = 1;
          else begin res = 2'd1; rw = 1; dn = 1; end
        end
        7'b0110011, 7'b0010011: begin
          sa = 2'd2;
          sb = (op == 7'b0110011) ? 2'd0 : 2'd1;
          case (f3)
            3'd0: alu = (op == 7'b0110011 && f7[5]) ? 3'd1 : 3'd0;
            3'd7: alu = 3'd2;
            3'd6: alu = 3'd3;
            3'd4: alu = 3'd4;
            3'd2: alu = 3'd5;
            default: alu = 3'd0;
          endcase
        end
        7'b1101111: begin sa = 2'd1; sb = 2'd2; pcw = 1; end
        7'b1100111: begin
          if (step == 2) begin sa = 2'd2; sb = 2'd1; res = 2'd2; pcw = 1; end
          else begin sa = 2'd1; sb = 2'd2; res = 2'd2; rw = 1; dn = 1; end
        end
        7'b1100011: begin
          sa = 2'd2; dn = 1;
          case (f3)
            3'd0: begin alu = 3'd1; pcw = zz;  end
            3'd1: begin alu = 3'd1; pcw = !zz; end
            3'd4: begin alu = 3'd5; pcw = !zz; end
            3'd5: begin alu = 3'd5; pcw = zz;  end
            default: pcw = 0;
          endcase
        end
        7'b0110111: begin res = 2'd3; rw = 1; dn = 1; end
        default: ;
      endcase
    end
    return {pcw, adr, mw, irw, res, sa, sb, alu, imm, rw, dn, ill};
  endfunction

  task automatic check(input string tag, input logic [18:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Runs the first nsteps cycles of an instruction; zsel<0 randomizes z per cycle.
  task automatic run_steps(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int zsel, input int nsteps);
    opcode = op; func3 = f3; func7 = f7;
    for (int s = 0; s < nsteps; s++) begin
      z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      @(negedge clk);
      check($sformatf("%s op=%b f3=%0d cyc%0d", name, op, f3, s + 1), model(op, f3, f7, s, z));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input int zsel);
    run_steps(name, op, f3, f7, zsel, instr_len(op));
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      z = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("reset cyc%0d", i), 19'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  logic [6:0] ops [0:8];

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0110111, 7'b1111111};
    rst = 1'b1; opcode = 7'b0110011; func3 = 3'd0; func7 = 7'd0; z = 1'b0;
    @(posedge clk); #1;
    reset_cycles(3);
    run_instr("rtype_add", 7'b0110011, 3'd0, 7'b0000000, 0);
    run_instr("lw",        7'b0000011, 3'd2, 7'd0, 0);
    run_instr("sw",        7'b0100011, 3'd2, 7'd0, 0);
    run_instr("sub",       7'b0110011, 3'd0, 7'b0100000, 0);
    run_instr("addi_f7",   7'b0010011, 3'd0, 7'b0100000, 0);
    run_instr("beq_z1",    7'b1100011, 3'd0, 7'd0, 1);
    run_instr("bne_z1",    7'b1100011, 3'd1, 7'd0, 1);
    run_instr("blt_z0",    7'b1100011, 3'd4, 7'd0, 0);
    run_instr("bge_z1",    7'b1100011, 3'd5, 7'd0, 1);
    run_instr("bx_f3_2",   7'b1100011, 3'd2, 7'd0, 1);
    run_instr("jal",       7'b1101111, 3'd0, 7'd0, 0);
    run_instr("jalr",      7'b1100111, 3'd0, 7'd0, 0);
    run_instr("lui",       7'b0110111, 3'd3, 7'd0, 0);
    run_instr("illegal",   7'b1111111, 3'd0, 7'd0, 0);
    run_instr("and",       7'b0110011, 3'd7, 7'd0, 0);
    run_instr("ori",       7'b0010011, 3'd6, 7'd0, 0);
    run_instr("xor",       7'b0110011, 3'd4, 7'd0, 0);
    run_instr("slti",      7'b0010011, 3'd2, 7'd0, 0);
    // Reset landing on the MEMWRITE cycle of a store.
    run_steps("sw_abort", 7'b0100011, 3'd2, 7'd0, 0, 3);
    reset_cycles(1);
    run_instr("after_abort", 7'b0000011, 3'd2, 7'd0, 0);
    for (int i = 0; i < 80; i++) begin
      logic [6:0] op;
      op = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : ops[$urandom_range(0, 8)];
      run_instr("rand", op, 3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
